hcms_display_ctrl: RTL and testbench

- Sequences the HCMS-29xx byte serializer (the load/ready byte transmitter) from power-up to continuous operation.
- Holds display reset, writes control word 1 then control word 0, then streams a local column-dot buffer to the display whenever it is dirty.
- Re-sends control word 0 when brightness or peak current changes.
- Host logic writes column bytes through a simple write port; this block owns the serializer and is its only requester.

---
 rtl/hcms_display_ctrl_if.sv | 10 +
 rtl/hcms_display_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hcms_display_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hcms_display_ctrl_if.sv
// Load/ready byte handshake between the display controller and the HCMS-29xx serializer.
interface hcms_display_ctrl_if;
  logic [7:0] o_tx_data;
  logic       o_tx_cmd;
  logic       o_tx_load;
  logic       i_tx_ready;

  modport master (output o_tx_data, output o_tx_cmd, output o_tx_load, input i_tx_ready);
  modport slave  (input o_tx_data, input o_tx_cmd, input o_tx_load, output i_tx_ready);
endinterface

// File: rtl/hcms_display_ctrl.sv
// HCMS-29xx sequencer: reset hold, control words 1 and 0, then streams the column buffer when dirty.
// state    | meaning
// RST_HOLD | display reset asserted for RESET_CYCLES cycles
// CW1      | sending control word 1 (8'h81)
// CW0      | sending control word 0 (peak current, brightness)
// IDLE     | waiting for a cfg update or a dirty buffer
// DOTS     | streaming buf[0..NUM_COLS-1] as dot data
module hcms_display_ctrl #(
  parameter int NUM_COLS     = 20,
  parameter int ADDR_W       = 5,
  parameter int RESET_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                r_reset,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [7:0]          i_wr_data,
  input  logic [3:0]          i_bright,
  input  logic [1:0]          i_peak,
  input  logic                i_cfg_update,
  hcms_display_ctrl_if.master tx,
  output logic                o_disp_reset,
  output logic                o_init_done,
  output logic                o_busy,
  output logic                o_frame_done
);
  localparam int CNT_W = $clog2(RESET_CYCLES) + 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 1);
  localparam logic [CNT_W-1:0]  LAST_RST = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {RST_HOLD, CW1, CW0, IDLE, DOTS} state_e;

  state_e            state_q, state_d;
  logic              rel_q, rel_d;
  logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [7:0]        data_q, data_d;
  logic              cmd_q, cmd_d;
  logic              dirty_q, dirty_d;
  logic              pend_q, pend_d;
  logic              init_q, init_d;
  logic              fdone_q, fdone_d;
  logic [7:0]        buf_q [NUM_COLS];

  logic              wr_ok;
  logic              sending;
  logic              byte_done;
  logic [7:0]        cw0;
  logic [ADDR_W-1:0] col_nxt;

  assign wr_ok     = i_wr_en && (i_wr_addr <= LAST_COL);
  assign sending   = (state_q == CW1) || (state_q == CW0) || (state_q == DOTS);
  assign byte_done = sending && rel_q && !tx.i_tx_ready;
  assign cw0       = {2'b01, i_peak, i_bright};
  assign col_nxt   = col_q + 1'b1;

  // Buffer contents survive reset so the host need not rewrite them.
  always_ff @(posedge i_clk) begin
    if (wr_ok) buf_q[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      state_q   <= RST_HOLD;
      rel_q     <= 1'b0;
      rst_cnt_q <= '0;
      col_q     <= '0;
      data_q    <= 8'h00;
      cmd_q     <= 1'b0;
      dirty_q   <= 1'b1;
      pend_q    <= 1'b0;
      init_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rel_q     <= rel_d;
      rst_cnt_q <= rst_cnt_d;
      col_q     <= col_d;
      data_q    <= data_d;
      cmd_q     <= cmd_d;
      dirty_q   <= dirty_d;
      pend_q    <= pend_d;
      init_q    <= init_d;
      fdone_q   <= fdone_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rel_d     = rel_q;
    rst_cnt_d = rst_cnt_q;
    col_d     = col_q;
    data_d    = data_q;
    cmd_d     = cmd_q;
    dirty_d   = dirty_q;
    pend_d    = pend_q | i_cfg_update;
    init_d    = init_q;
    fdone_d   = 1'b0;

    if (sending && !rel_q && tx.i_tx_ready) rel_d = 1'b1;

    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == LAST_RST) begin
          state_d = CW1;
          data_d  = 8'h81;
          cmd_d   = 1'b1;
          rel_d   = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      CW1: begin
        if (byte_done) begin
          state_d = CW0;
          data_d  = cw0;
          cmd_d   = 1'b1;
          rel_d   = 1'b0;
        end
      end
      CW0: begin
        if (byte_done) begin
          state_d = IDLE;
          rel_d   = 1'b0;
          init_d  = 1'b1;
          // Requests raised during initialisation are covered by the init CW0.
          if (!init_q) pend_d = 1'b0;
        end
      end
      IDLE: begin
        if (pend_q || i_cfg_update) begin
          state_d = CW0;
          data_d  = cw0;
          cmd_d   = 1'b1;
          rel_d   = 1'b0;
          pend_d  = 1'b0;
        end else if (dirty_q) begin
          state_d = DOTS;
          dirty_d = 1'b0;
          col_d   = '0;
          data_d  = buf_q[0];
          cmd_d   = 1'b0;
          rel_d   = 1'b0;
        end
      end
      DOTS: begin
        if (byte_done) begin
          if (col_q == LAST_COL) begin
            state_d = IDLE;
            rel_d   = 1'b0;
            fdone_d = 1'b1;
          end else begin
            col_d  = col_nxt;
            data_d = buf_q[col_nxt];
            rel_d  = 1'b0;
          end
        end
      end
      default: state_d = RST_HOLD;
    endcase

    // A write always wins over the IDLE clear so the new data gets its own frame.
    if (wr_ok) dirty_d = 1'b1;
  end

  assign tx.o_tx_data  = data_q;
  assign tx.o_tx_cmd   = cmd_q;
  assign tx.o_tx_load  = sending && !rel_q;
  assign o_disp_reset  = (state_q == RST_HOLD);
  assign o_init_done   = init_q;
  assign o_busy        = (state_q != IDLE);
  assign o_frame_done  = fdone_q;
endmodule

// File: tb/tb_hcms_display_ctrl.sv
// Scoreboard bench for hcms_display_ctrl with a load/ready serializer model.
module tb_hcms_display_ctrl;
  localparam int NUM_COLS = 20;
  localparam int ADDR_W   = 5;

  logic              i_clk = 1'b0;
  logic              r_reset = 1'b1;
  logic              i_wr_en = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [7:0]        i_wr_data = 8'h00;
  logic [3:0]        i_bright = 4'hF;
  logic [1:0]        i_peak = 2'b00;
  logic              i_cfg_update = 1'b0;
  logic              o_disp_reset, o_init_done, o_busy, o_frame_done;

  hcms_display_ctrl_if tx_if();

  hcms_display_ctrl #(.NUM_COLS(NUM_COLS), .ADDR_W(ADDR_W), .RESET_CYCLES(16)) dut (
    .i_clk        (i_clk),
    .r_reset      (r_reset),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_bright     (i_bright),
    .i_peak       (i_peak),
    .i_cfg_update (i_cfg_update),
    .tx           (tx_if),
    .o_disp_reset (o_disp_reset),
    .o_init_done  (o_init_done),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int         checks = 0;
  int         failures = 0;
  int         n_loads = 0;
  int         n_frames = 0;
  logic [8:0] exp_q [$];
  logic [7:0] model [NUM_COLS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < NUM_COLS; i++) exp_q.push_back({1'b0, model[i]});
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic wait_loads(input int target, input string name);
    int n = 0;
    while (n_loads < target && n < 2000) begin @(posedge i_clk); n++; end
    #1;
    chk(name, 32'(n_loads >= target), 32'd1);
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (n_frames < target && n < 3000) begin @(posedge i_clk); n++; end
    #1;
    chk(name, 32'(n_frames >= target), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((o_busy || exp_q.size() != 0 || tx_if.i_tx_ready) && n < 2000) begin
      @(posedge i_clk); n++;
    end
    #1;
    chk(name, 32'(!o_busy && exp_q.size() == 0), 32'd1);
  endtask

  // Serializer model: ready 10 cycles into a load, dropped one cycle after load falls.
  initial begin
    int rcnt = 0;
    tx_if.i_tx_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (tx_if.i_tx_ready) begin
        if (!tx_if.o_tx_load) tx_if.i_tx_ready = 1'b0;
      end else if (tx_if.o_tx_load) begin
        rcnt++;
        if (rcnt == 10) begin tx_if.i_tx_ready = 1'b1; rcnt = 0; end
      end else begin
        rcnt = 0;
      end
    end
  end

  // Monitor: pops one expectation per new load, checks stability and frame pulses.
  logic       prev_load = 1'b0, prev_ready = 1'b0, prev_fd = 1'b0;
  logic [8:0] cap = '0;
  always @(negedge i_clk) begin
    if (!r_reset) begin
      if (tx_if.o_tx_load && !prev_load) begin
        n_loads++;
        cap = {tx_if.o_tx_cmd, tx_if.o_tx_data};
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load: actual=%0h required=none", cap);
        end else begin
          chk("tx_byte", {23'd0, cap}, {23'd0, exp_q.pop_front()});
        end
      end else if (prev_load) begin
        chk("tx_stable", {23'd0, tx_if.o_tx_cmd, tx_if.o_tx_data}, {23'd0, cap});
      end
      if (prev_load && prev_ready && tx_if.o_tx_load) begin
        checks++; failures++;
        $display("FAIL load_after_ready: actual=1 required=0");
      end
      if (o_frame_done) begin
        n_frames++;
        if (prev_fd) begin
          checks++; failures++;
          $display("FAIL frame_done_width: actual=2+ cycles required=1");
        end
      end
    end
    prev_load  = tx_if.o_tx_load && !r_reset;
    prev_ready = tx_if.i_tx_ready;
    prev_fd    = o_frame_done;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: actual=expired required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int cnt;
    for (int i = 0; i < NUM_COLS; i++) model[i] = 8'(8'h10 + i);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_disp_reset", 32'(o_disp_reset), 32'd1);
    chk("rst_tx_load", 32'(tx_if.o_tx_load), 32'd0);
    chk("rst_tx_cmd", 32'(tx_if.o_tx_cmd), 32'd0);
    chk("rst_tx_data", 32'(tx_if.o_tx_data), 32'd0);
    chk("rst_init_done", 32'(o_init_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd1);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);

    // Init sequence: CW1, CW0 (peak 00, bright F), then a full frame of the buffer.
    exp_q.push_back({1'b1, 8'h81});
    exp_q.push_back({1'b1, 8'h4F});
    push_frame();
    @(posedge i_clk); #1;
    r_reset = 1'b0;
    fork
      begin
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge i_clk);
          if (o_disp_reset) cnt++;
          else break;
        end
        chk("disp_reset_cycles", 32'(cnt), 32'd16);
      end
      begin
        for (int i = 0; i < NUM_COLS; i++) wr(ADDR_W'(i), model[i]);
      end
    join
    wait_frames(1, "init_frame_timeout");
    wait_idle("init_idle_timeout");
    chk("init_done", 32'(o_init_done), 32'd1);
    chk("init_busy", 32'(o_busy), 32'd0);

    // Single write while idle: exactly one frame.
    model[3] = 8'hAA;
    push_frame();
    wr(5'd3, 8'hAA);
    wait_frames(2, "wr3_frame_timeout");
    wait_idle("wr3_idle_timeout");
    repeat (200) @(posedge i_clk);
    #1;
    chk("wr3_frame_count", 32'(n_frames), 32'd2);

    // Write to column 19 during byte 5: both frames carry it, two frames total.
    model[7]  = 8'h77;
    model[19] = 8'h55;
    push_frame();
    push_frame();
    base = n_loads;
    wr(5'd7, 8'h77);
    wait_loads(base + 6, "wr19_byte5_timeout");
    wr(5'd19, 8'h55);
    wait_frames(4, "wr19_frame_timeout");
    wait_idle("wr19_idle_timeout");
    repeat (200) @(posedge i_clk);
    #1;
    chk("wr19_frame_count", 32'(n_frames), 32'd4);

    // Cfg update mid-frame: frame finishes, then one CW0 = 8'h53, no extra dots.
    i_bright = 4'h3;
    i_peak   = 2'b01;
    model[0] = 8'h01;
    push_frame();
    exp_q.push_back({1'b1, 8'h53});
    base = n_loads;
    wr(5'd0, 8'h01);
    wait_loads(base + 6, "cfg_byte5_timeout");
    i_cfg_update = 1'b1;
    @(posedge i_clk); #1;
    i_cfg_update = 1'b0;
    wait_frames(5, "cfg_frame_timeout");
    wait_idle("cfg_idle_timeout");
    repeat (200) @(posedge i_clk);
    #1;
    chk("cfg_frame_count", 32'(n_frames), 32'd5);
    chk("cfg_load_count", 32'(n_loads - base), 32'd21);

    // Out-of-range address is ignored.
    base = n_loads;
    wr(5'd25, 8'hEE);
    repeat (100) @(posedge i_clk);
    @(negedge i_clk);
    chk("addr25_busy", 32'(o_busy), 32'd0);
    chk("addr25_loads", 32'(n_loads - base), 32'd0);

    // Reset while a byte load is pending aborts and restarts from RST_HOLD.
    model[2] = 8'h22;
    exp_q.push_back({1'b0, model[0]});
    base = n_loads;
    wr(5'd2, 8'h22);
    wait_loads(base + 1, "abort_load_timeout");
    chk("abort_load_high", 32'(tx_if.o_tx_load), 32'd1);
    r_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("abort_load_low", 32'(tx_if.o_tx_load), 32'd0);
    chk("abort_disp_reset", 32'(o_disp_reset), 32'd1);
    chk("abort_init_done", 32'(o_init_done), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd1);
    chk("abort_tx_data", 32'(tx_if.o_tx_data), 32'd0);
    repeat (2) @(posedge i_clk);
    exp_q.push_back({1'b1, 8'h81});
    exp_q.push_back({1'b1, 8'h53});
    push_frame();
    #1;
    r_reset = 1'b0;
    wait_frames(6, "restart_frame_timeout");
    wait_idle("restart_idle_timeout");
    chk("restart_init_done", 32'(o_init_done), 32'd1);
    repeat (50) @(posedge i_clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_frame_count", 32'(n_frames), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
